// File: rtl/dtimer_preset_if.sv
// Button/display bundle between the debounced push-buttons, the preset
// editor and the countdown counter's preset inputs.
interface dtimer_preset_if;
    logic       btn_sel;
    logic       btn_inc;
    logic       btn_dec;
    logic       btn_set;
    logic       run_active;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic       load;
    logic [1:0] edit_field;

    // Button side: drives levels, watches digits and load.
    modport master (
        output btn_sel, btn_inc, btn_dec, btn_set, run_active,
        input  min1, min0, sec1, sec0, load, edit_field
    );

    // Editor side.
    modport slave (
        input  btn_sel, btn_inc, btn_dec, btn_set, run_active,
        output min1, min0, sec1, sec0, load, edit_field
    );
endinterface

// File: rtl/dtimer_preset.sv
// Preset editor for the mm:ss BCD countdown timer: field select, BCD
// up/down stepping with auto-repeat, cancel, and a one-cycle commit pulse.
module dtimer_preset #(
    parameter int DEF_MIN  = 0,
    parameter int DEF_SEC  = 30,
    parameter int HOLD_CYC = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    dtimer_preset_if.slave   bus
);

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [7:0] DEF_MIN_BCD = {4'(DEF_MIN / 10), 4'(DEF_MIN % 10)};
    localparam logic [7:0] DEF_SEC_BCD = {4'(DEF_SEC / 10), 4'(DEF_SEC % 10)};

    typedef enum logic [1:0] {S_IDLE, S_EDIT_MIN, S_EDIT_SEC, S_LOAD} state_t;

    state_t           state, state_d;
    logic [7:0]       wmin, wsec, cmin, csec;
    logic [7:0]       wmin_d, wsec_d, cmin_d, csec_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       prev;
    logic             p_sel, p_inc, p_dec, p_set;
    logic             held_one, step, up;

    // Two-digit BCD increment; tens wraps to 0 past tmax. Out-of-range
    // digits are pulled back into range rather than propagated.
    function automatic logic [7:0] bcd_up(input logic [7:0] v, input logic [3:0] tmax);
        logic [3:0] t, u;
        t = v[7:4];
        u = v[3:0];
        if (u >= 4'd9) begin
            u = 4'd0;
            t = (t >= tmax) ? 4'd0 : t + 4'd1;
        end else begin
            u = u + 4'd1;
        end
        return {t, u};
    endfunction

    // Two-digit BCD decrement; tens wraps to tmax below 0.
    function automatic logic [7:0] bcd_dn(input logic [7:0] v, input logic [3:0] tmax);
        logic [3:0] t, u;
        t = v[7:4];
        u = v[3:0];
        if (u == 4'd0 || u > 4'd9) begin
            u = 4'd9;
            t = (t == 4'd0 || t > tmax) ? tmax : t - 4'd1;
        end else begin
            u = u - 4'd1;
        end
        return {t, u};
    endfunction

    assign p_set    = bus.btn_set & ~prev[3];
    assign p_sel    = bus.btn_sel & ~prev[2];
    assign p_inc    = bus.btn_inc & ~prev[1];
    assign p_dec    = bus.btn_dec & ~prev[0];
    assign held_one = bus.btn_inc ^ bus.btn_dec;

    // Next-state, working/committed digit and hold-counter logic.
    always_comb begin
        state_d = state;
        wmin_d  = wmin;
        wsec_d  = wsec;
        cmin_d  = cmin;
        csec_d  = csec;
        cnt_d   = '0;
        step    = 1'b0;
        up      = bus.btn_inc;
        case (state)
            S_IDLE: begin
                if (!bus.run_active && p_sel) state_d = S_EDIT_MIN;
            end
            S_EDIT_MIN, S_EDIT_SEC: begin
                if (bus.run_active) begin
                    state_d = S_IDLE;
                    wmin_d  = cmin;
                    wsec_d  = csec;
                end else if (p_set) begin
                    state_d = S_LOAD;
                end else if (p_sel) begin
                    if (state == S_EDIT_MIN) begin
                        state_d = S_EDIT_SEC;
                    end else begin
                        state_d = S_IDLE;
                        wmin_d  = cmin;
                        wsec_d  = csec;
                    end
                end else if (held_one) begin
                    // A fresh press steps immediately; a held button steps
                    // each time the counter wraps.
                    if (p_inc || p_dec || cnt == CNT_LAST) begin
                        step = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                if (step) begin
                    if (state == S_EDIT_MIN) wmin_d = up ? bcd_up(wmin, 4'd9) : bcd_dn(wmin, 4'd9);
                    else                     wsec_d = up ? bcd_up(wsec, 4'd5) : bcd_dn(wsec, 4'd5);
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
                cmin_d  = wmin;
                csec_d  = wsec;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Digits, hold counter and button history. History loads the current
    // levels in reset so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            wmin <= DEF_MIN_BCD;
            wsec <= DEF_SEC_BCD;
            cmin <= DEF_MIN_BCD;
            csec <= DEF_SEC_BCD;
            cnt  <= '0;
        end else begin
            wmin <= wmin_d;
            wsec <= wsec_d;
            cmin <= cmin_d;
            csec <= csec_d;
            cnt  <= cnt_d;
        end
        prev <= {bus.btn_set, bus.btn_sel, bus.btn_inc, bus.btn_dec};
    end

    assign bus.min1 = wmin[7:4];
    assign bus.min0 = wmin[3:0];
    assign bus.sec1 = wsec[7:4];
    assign bus.sec0 = wsec[3:0];
    assign bus.load = (state == S_LOAD);
    assign bus.edit_field = (state == S_EDIT_MIN) ? 2'b01 :
                            (state == S_EDIT_SEC) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_dtimer_preset.sv
// Bench for the preset editor: directed scenarios plus random button
// activity, all compared against an integer-arithmetic reference model.
module tb_dtimer_preset;

    localparam int HOLD = 4;
    // Button vector layout: {run_active, set, sel, inc, dec}
    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_RUN  = 5'b10000;
    localparam logic [4:0] B_SET  = 5'b01000;
    localparam logic [4:0] B_SEL  = 5'b00100;
    localparam logic [4:0] B_INC  = 5'b00010;
    localparam logic [4:0] B_DEC  = 5'b00001;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    dtimer_preset_if bus();

    dtimer_preset #(.DEF_MIN(0), .DEF_SEC(30), .HOLD_CYC(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer minutes/seconds with modular stepping.
    int         m_wmin, m_wsec, m_cmin, m_csec;
    int         m_mode;   // 0 idle, 1 minutes, 2 seconds, 3 load cycle
    int         m_age;    // cycles since the last step while one button held
    logic [4:0] m_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] dig();
        return {bus.min1, bus.min0, bus.sec1, bus.sec0};
    endfunction

    task automatic model_step(input logic r, input logic [4:0] b);
        logic p_set, p_sel, p_inc, p_dec;
        int   dir;
        if (r) begin
            m_wmin = 0; m_wsec = 30; m_cmin = 0; m_csec = 30;
            m_mode = 0; m_age = 0; m_prev = b;
            return;
        end
        p_set = b[3] & ~m_prev[3];
        p_sel = b[2] & ~m_prev[2];
        p_inc = b[1] & ~m_prev[1];
        p_dec = b[0] & ~m_prev[0];
        dir = 0;
        case (m_mode)
            3: begin
                m_cmin = m_wmin; m_csec = m_wsec; m_mode = 0; m_age = 0;
            end
            0: begin
                if (!b[4] && p_sel) m_mode = 1;
                m_age = 0;
            end
            default: begin
                if (b[4]) begin
                    m_wmin = m_cmin; m_wsec = m_csec; m_mode = 0; m_age = 0;
                end else if (p_set) begin
                    m_mode = 3; m_age = 0;
                end else if (p_sel) begin
                    m_age = 0;
                    if (m_mode == 1) m_mode = 2;
                    else begin m_wmin = m_cmin; m_wsec = m_csec; m_mode = 0; end
                end else if (b[1] != b[0]) begin
                    if (p_inc || p_dec) begin
                        dir = b[1] ? 1 : -1; m_age = 0;
                    end else begin
                        m_age++;
                        if (m_age == HOLD) begin dir = b[1] ? 1 : -1; m_age = 0; end
                    end
                end else begin
                    m_age = 0;
                end
                if (dir != 0) begin
                    if (m_mode == 1) m_wmin = (m_wmin + dir + 100) % 100;
                    else             m_wsec = (m_wsec + dir + 60) % 60;
                end
            end
        endcase
        m_prev = b;
    endtask

    // One clock: drive levels, clock, advance the model, compare after the edge.
    task automatic tick(input logic r, input logic [4:0] b);
        rst            = r;
        bus.run_active = b[4];
        bus.btn_set    = b[3];
        bus.btn_sel    = b[2];
        bus.btn_inc    = b[1];
        bus.btn_dec    = b[0];
        @(posedge clk);
        model_step(r, b);
        #1;
        check("digits", 32'(dig()), 32'(to_bcd(m_wmin, m_wsec)));
        check("load", 32'(bus.load), 32'(m_mode == 3));
        check("edit_field", 32'(bus.edit_field),
              32'((m_mode == 1) ? 1 : (m_mode == 2) ? 2 : 0));
    endtask

    task automatic press(input logic [4:0] b);
        tick(1'b0, b);
        tick(1'b0, B_NONE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] lv;
        logic       r;
        n_tests = 0;
        n_fail  = 0;
        m_prev  = '0;
        rst = 1'b1;
        bus.btn_sel = 0; bus.btn_inc = 0; bus.btn_dec = 0;
        bus.btn_set = 0; bus.run_active = 0;

        // Reset state
        tick(1'b1, B_NONE);
        tick(1'b1, B_NONE);
        check("reset_digits", 32'(dig()), 32'h0030);
        check("reset_load", 32'(bus.load), 0);
        tick(1'b0, B_NONE);

        // Edit minutes to 03 and commit
        press(B_SEL);
        check("t2_field_min", 32'(bus.edit_field), 1);
        repeat (3) press(B_INC);
        tick(1'b0, B_SET);
        check("t2_load_hi", 32'(bus.load), 1);
        check("t2_load_digits", 32'(dig()), 32'h0330);
        tick(1'b0, B_NONE);
        check("t2_load_lo", 32'(bus.load), 0);
        check("t2_idle", 32'(bus.edit_field), 0);

        // Minutes wrap 00 <-> 99, seconds wrap 59 <-> 00, then cancel
        press(B_SEL);
        repeat (3) press(B_DEC);
        press(B_DEC);
        check("t3_min_99", 32'(dig()), 32'h9930);
        press(B_INC);
        check("t3_min_00", 32'(dig()), 32'h0030);
        press(B_SEL);
        repeat (31) press(B_DEC);
        check("t3_sec_59", 32'(dig()), 32'h0059);
        press(B_INC);
        check("t3_sec_00", 32'(dig()), 32'h0000);
        press(B_DEC);
        check("t3_sec_back", 32'(dig()), 32'h0059);
        press(B_SEL);
        check("t3_cancel", 32'(dig()), 32'h0330);

        // Commit 05:30, edit to 07, run_active reverts and blocks presses
        press(B_SEL);
        repeat (2) press(B_INC);
        press(B_SET);
        press(B_SEL);
        repeat (2) press(B_INC);
        check("t4_min_07", 32'(dig()), 32'h0730);
        tick(1'b0, B_RUN);
        check("t4_revert", 32'(dig()), 32'h0530);
        check("t4_idle", 32'(bus.edit_field), 0);
        tick(1'b0, B_RUN | B_SEL);
        tick(1'b0, B_RUN | B_SET);
        check("t4_blocked", 32'(bus.edit_field), 0);
        check("t4_noload", 32'(bus.load), 0);
        tick(1'b0, B_NONE);

        // Auto-repeat in seconds from 10, then inc+dec held together
        press(B_SEL);
        press(B_SEL);
        repeat (20) press(B_DEC);
        check("t5_sec_10", 32'(dig()), 32'h0510);
        repeat (13) tick(1'b0, B_INC);
        check("t5_repeat", 32'(dig()), 32'h0514);
        tick(1'b0, B_NONE);
        repeat (10) tick(1'b0, B_INC | B_DEC);
        check("t5_both", 32'(dig()), 32'h0514);
        tick(1'b0, B_NONE);
        press(B_SEL);

        // set during reset, inc held across reset release
        press(B_SEL);
        tick(1'b1, B_SET | B_INC);
        check("t6_noload", 32'(bus.load), 0);
        check("t6_reset", 32'(dig()), 32'h0030);
        repeat (6) tick(1'b0, B_INC);
        check("t6_nostep", 32'(dig()), 32'h0030);
        tick(1'b0, B_NONE);
        press(B_SEL);
        press(B_INC);
        check("t6_step", 32'(dig()), 32'h0130);
        press(B_SEL);
        press(B_SEL);

        // Random button activity
        lv = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(3) == 0) lv[k] = ~lv[k];
            if ($urandom_range(39) == 0) lv[4] = ~lv[4];
            r = ($urandom_range(499) == 0);
            tick(r, lv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
